stream_take_sum: RTL and testbench
==================================

STREAM_TAKE_SUM -- requirements
Module: stream_take_sum

Interface
REQ-001 Parameter: intN, default 8, data width of stream elements, count and sum.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: nrst  in  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  in  1  request valid; count is valid when high.
REQ-005 Port: in_ready  out  1  block can accept a new request.
REQ-006 Port: count  in  intN  number of stream elements to consume, unsigned.
REQ-007 Port: sIn  in  intN  stream element from the upstream repeat/stream producer.
REQ-008 Port: sIn_valid  in  1  stream element valid.
REQ-009 Port: sIn_ready  out  1  block consumes the stream element this cycle.
REQ-010 Port: out_valid  out  1  sum result valid.
REQ-011 Port: out_ready  in  1  downstream accepts the result.
REQ-012 Port: sum  out  intN  sum of the consumed elements, modulo 2^intN.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE: in_ready=1, sIn_ready=0, out_valid=0.
REQ-015 IDLE transitions: in_valid=1 latches count into remaining and clears acc. Next state is RUN if count!=0, else DONE.
REQ-016 RUN: in_ready=0, sIn_ready=1, out_valid=0.
REQ-017 RUN transfer: each cycle with sIn_valid=1 is one element; acc<=acc+sIn (truncated to intN bits, carry discarded) and remaining<=remaining-1.
REQ-018 RUN with sIn_valid=0: acc and remaining SHALL hold; no timeout.
REQ-019 RUN exit: the transfer that makes remaining reach 0 moves the FSM to DONE on the same edge; exactly count elements are consumed per request, never more.
REQ-020 DONE: out_valid=1, sum=acc, in_ready=0, sIn_ready=0.
REQ-021 DONE hold: sum SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 DONE exit: out_ready=1 completes the handshake and moves to IDLE; a new request is accepted no earlier than the following cycle.
REQ-023 Latency: request accepted at edge T with count=k and sIn_valid held high gives transfers at edges T+1..T+k and out_valid high in the cycle after edge T+k. With count=0, out_valid is high in the cycle after edge T.
REQ-024 count=2^intN-1: SHALL consume exactly 2^intN-1 elements; remaining has no wrap or underflow.
REQ-025 Signal changes: in_valid or count changing while not in IDLE SHALL be ignored; the latched count governs the run.
REQ-026 Combinational paths: in_ready, sIn_ready, out_valid and sum SHALL be decoded from registered state only; there is no combinational path from any input to any output.

Reset
REQ-027 nrst low SHALL immediately force state=IDLE, acc=0 and remaining=0. Outputs: in_ready=1, sIn_ready=0, out_valid=0, sum=0.
REQ-028 Reset mid-RUN or mid-DONE SHALL abandon the operation; the partial sum is never presented.
REQ-029 After nrst deasserts, the first request SHALL be accepted on the first rising edge with in_valid=1.

Verification
REQ-030 Basic sum: sIn=42 with sIn_valid always 1, count=3, out_ready=1 -> exactly 3 transfers, out_valid for 1 cycle with sum=126, then in_ready=1.
REQ-031 Wrap-around: intN=8, sIn=100, count=3 -> sum=44 (300 mod 256); count=0 -> out_valid in the cycle after acceptance with sum=0 and sIn_ready never high.
REQ-032 Stream gaps: sIn=5, count=4, sIn_valid toggling 1,0,1,0,... -> 4 transfers over 7 cycles, sum=20, no element consumed while sIn_valid=0.
REQ-033 Output backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and sum=126 held stable, sIn_ready=0 and in_ready=0 throughout; out_ready=1 -> IDLE next edge.
REQ-034 Reset mid-run: count=10, nrst pulsed low after 4 transfers -> outputs reset immediately. A new request with count=2 and sIn=7 then gives sum=14.
REQ-035 Back-to-back: two requests (count=2 with sIn=1, then count=3 with sIn=2) -> sums 2 and 6 in order, with no extra stream transfers between the requests.

Source files
------------

// File: rtl/stream_take_sum_if.sv
// Request / stream / result handshake bundle for stream_take_sum.
// The master side issues requests, supplies stream elements and takes results.
// The slave side is the summing block.
interface stream_take_sum_if #(
    parameter int intN = 8
);
    // request channel
    logic            in_valid;
    logic            in_ready;
    logic [intN-1:0] count;

    // element stream
    logic [intN-1:0] sIn;
    logic            sIn_valid;
    logic            sIn_ready;

    // result channel
    logic            out_valid;
    logic            out_ready;
    logic [intN-1:0] sum;

    modport master (
        output in_valid, count, sIn, sIn_valid, out_ready,
        input  in_ready, sIn_ready, out_valid, sum
    );

    modport slave (
        input  in_valid, count, sIn, sIn_valid, out_ready,
        output in_ready, sIn_ready, out_valid, sum
    );
endinterface

// File: rtl/stream_take_sum.sv
// Takes a request carrying an element count, consumes exactly that many
// stream elements, and presents their sum (modulo 2^intN) until the
// downstream accepts it. All handshake outputs are decoded from registered
// state, so there is no combinational path from any input to any output.
module stream_take_sum #(
    parameter int intN = 8
) (
    input logic             clk,
    input logic             nrst,
    stream_take_sum_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [intN-1:0] ONE = {{(intN-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [intN-1:0] acc_q, acc_d;
    logic [intN-1:0] remaining_q, remaining_d;

    // Next-state logic: accept a request, accumulate elements, hand off the result.
    always_comb begin
        // NOTE: every value gets a default before the case so no path leaves
        // one unassigned; a missing default here would infer a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    remaining_d = bus.count;
                    acc_d       = '0;
                    // A zero-length request skips straight to presenting 0.
                    state_d     = (bus.count != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // Without a valid element everything holds; there is no timeout.
                if (bus.sIn_valid) begin
                    acc_d       = acc_q + bus.sIn;
                    remaining_d = remaining_q - ONE;
                    // Leave on the edge of the last element so no extra one is taken.
                    if (remaining_q == ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: all three registers are reset so an abandoned run can never
        // leak a partial sum or a stale element count into the next request.
        if (!nrst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the values present before the edge, matching the hardware.
            state_q     <= state_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.sIn_ready = (state_q == RUN);
        bus.out_valid = (state_q == DONE);
        // The accumulator is only visible once the run is complete.
        bus.sum       = (state_q == DONE) ? acc_q : '0;
    end

endmodule

// File: tb/tb_stream_take_sum.sv
// Directed bench for stream_take_sum: reset, basic sum, wrap-around, empty
// request, stream gaps, output backpressure, reset mid-run, back-to-back and
// maximum count. Inputs change 1 time unit after the rising edge; outputs are
// read at that same point, well away from the edge.
module tb_stream_take_sum;

    localparam int W = 8;

    logic clk;
    logic nrst;
    int   checks;
    int   errors;
    int   xfer_cnt;

    stream_take_sum_if #(.intN(W)) bus ();

    stream_take_sum #(.intN(W)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts handshakes on the falling edge, where the values that the next
    // rising edge will act on are already stable.
    always @(negedge clk) begin
        if (nrst && bus.sIn_valid && bus.sIn_ready) begin
            xfer_cnt <= xfer_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns just after the accepting edge.
    task automatic start_req(input logic [W-1:0] k, input logic [W-1:0] s);
        bus.in_valid = 1'b1;
        bus.count    = k;
        bus.sIn      = s;
        step();
        bus.in_valid = 1'b0;
        bus.count    = 8'hA5;   // later changes must not affect the run
    endtask

    task automatic test_reset();
        nrst          = 1'b1;
        bus.in_valid  = 1'b0;
        bus.count     = '0;
        bus.sIn       = '0;
        bus.sIn_valid = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        nrst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.sIn_ready !== 1'b0) begin errors++; $display("FAIL reset_sIn_ready: got %b want 0", bus.sIn_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.sum !== 8'd0) begin errors++; $display("FAIL reset_sum: got %0d want 0", bus.sum); end
        step();
        step();
        nrst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int base;
        base          = xfer_cnt;
        bus.sIn_valid = 1'b1;
        bus.out_ready = 1'b1;
        start_req(8'd3, 8'd42);
        checks++; if (bus.sIn_ready !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_run_flags: got sIn_ready=%b in_ready=%b want 1 0", bus.sIn_ready, bus.in_ready); end
        step();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", bus.out_valid); end
        step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.sum !== 8'd126) begin errors++; $display("FAIL basic_sum: got %0d want 126", bus.sum); end
        checks++; if (bus.sIn_ready !== 1'b0) begin errors++; $display("FAIL basic_done_sIn_ready: got %b want 0", bus.sIn_ready); end
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_back_idle: got out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready); end
        checks++; if (xfer_cnt - base !== 3) begin errors++; $display("FAIL basic_xfers: got %0d want 3", xfer_cnt - base); end
    endtask

    task automatic test_wrap();
        int base;
        base          = xfer_cnt;
        bus.sIn_valid = 1'b1;
        bus.out_ready = 1'b1;
        start_req(8'd3, 8'd100);
        step();
        step();
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 8'd44) begin errors++; $display("FAIL wrap_sum: got valid=%b sum=%0d want 1 44", bus.out_valid, bus.sum); end
        step();
        checks++; if (xfer_cnt - base !== 3) begin errors++; $display("FAIL wrap_xfers: got %0d want 3", xfer_cnt - base); end

        base = xfer_cnt;
        start_req(8'd0, 8'd100);
        checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 8'd0) begin errors++; $display("FAIL zero_result: got valid=%b sum=%0d want 1 0", bus.out_valid, bus.sum); end
        checks++; if (bus.sIn_ready !== 1'b0) begin errors++; $display("FAIL zero_sIn_ready: got %b want 0", bus.sIn_ready); end
        step();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL zero_back_idle: got %b want 1", bus.in_ready); end
        checks++; if (xfer_cnt - base !== 0) begin errors++; $display("FAIL zero_xfers: got %0d want 0", xfer_cnt - base); end
    endtask

    task automatic test_gaps();
        int base;
        base          = xfer_cnt;
        bus.sIn_valid = 1'b0;
        bus.out_ready = 1'b1;
        start_req(8'd4, 8'd5);
        for (int i = 0; i < 7; i++) begin
            bus.sIn_valid = (i % 2 == 0);
            bus.sIn       = (i % 2 == 0) ? 8'd5 : 8'd99;
            // A stray request mid-run must be ignored.
            bus.in_valid  = (i == 2);
            bus.count     = 8'd1;
            step();
            if (i == 5) begin
                checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL gaps_early_valid: got %b want 0", bus.out_valid); end
            end
        end
        bus.in_valid  = 1'b0;
        bus.sIn_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 8'd20) begin errors++; $display("FAIL gaps_sum: got valid=%b sum=%0d want 1 20", bus.out_valid, bus.sum); end
        checks++; if (xfer_cnt - base !== 4) begin errors++; $display("FAIL gaps_xfers: got %0d want 4", xfer_cnt - base); end
        step();
    endtask

    task automatic test_backpressure();
        bus.sIn_valid = 1'b1;
        bus.out_ready = 1'b0;
        start_req(8'd3, 8'd42);
        step();
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.sum !== 8'd126 || bus.sIn_ready !== 1'b0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b sum=%0d sIn_ready=%b in_ready=%b want 1 126 0 0",
                         i, bus.out_valid, bus.sum, bus.sIn_ready, bus.in_ready);
            end
            step();
        end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got in_ready=%b valid=%b want 1 0", bus.in_ready, bus.out_valid); end
    endtask

    task automatic test_reset_mid_run();
        int base;
        bus.sIn_valid = 1'b1;
        bus.out_ready = 1'b1;
        start_req(8'd10, 8'd3);
        for (int i = 0; i < 4; i++) step();
        #1;
        nrst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.sIn_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.sum !== 8'd0) begin
            errors++;
            $display("FAIL midrun_reset: got in_ready=%b sIn_ready=%b valid=%b sum=%0d want 1 0 0 0",
                     bus.in_ready, bus.sIn_ready, bus.out_valid, bus.sum);
        end
        nrst = 1'b1;
        base = xfer_cnt;
        start_req(8'd2, 8'd7);
        checks++; if (bus.sIn_ready !== 1'b1) begin errors++; $display("FAIL midrun_first_accept: got %b want 1", bus.sIn_ready); end
        step();
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 8'd14) begin errors++; $display("FAIL midrun_new_sum: got valid=%b sum=%0d want 1 14", bus.out_valid, bus.sum); end
        checks++; if (xfer_cnt - base !== 2) begin errors++; $display("FAIL midrun_xfers: got %0d want 2", xfer_cnt - base); end
        step();
    endtask

    task automatic test_back_to_back();
        int base;
        base          = xfer_cnt;
        bus.sIn_valid = 1'b1;
        bus.out_ready = 1'b1;
        start_req(8'd2, 8'd1);
        step();
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 8'd2) begin errors++; $display("FAIL b2b_first: got valid=%b sum=%0d want 1 2", bus.out_valid, bus.sum); end
        // Second request waits while the first result is being handed off.
        bus.in_valid = 1'b1;
        bus.count    = 8'd3;
        bus.sIn      = 8'd2;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_gap: got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid: got %b want 0", bus.out_valid); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 8'd6) begin errors++; $display("FAIL b2b_second: got valid=%b sum=%0d want 1 6", bus.out_valid, bus.sum); end
        checks++; if (xfer_cnt - base !== 5) begin errors++; $display("FAIL b2b_xfers: got %0d want 5", xfer_cnt - base); end
        step();
    endtask

    task automatic test_max_count();
        int base;
        base          = xfer_cnt;
        bus.sIn_valid = 1'b1;
        bus.out_ready = 1'b1;
        start_req(8'd255, 8'd1);
        for (int i = 0; i < 254; i++) step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL max_early_valid: got %b want 0", bus.out_valid); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 8'd255) begin errors++; $display("FAIL max_sum: got valid=%b sum=%0d want 1 255", bus.out_valid, bus.sum); end
        checks++; if (xfer_cnt - base !== 255) begin errors++; $display("FAIL max_xfers: got %0d want 255", xfer_cnt - base); end
        step();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        xfer_cnt = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_gaps();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_max_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
